// File: rtl/cpu_pkg.sv
// Shared CPU width constants and reset vector used by the core's front-end blocks.
package cpu_pkg;

    localparam int unsigned CPU_AWIDTH   = 16;
    localparam int unsigned CPU_IWIDTH   = 16;
    localparam int unsigned CPU_DWIDTH   = 16;
    localparam int unsigned CPU_NREGS    = 16;
    localparam int unsigned CPU_RESET_PC = 0;

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch queue storage: DEPTH x WIDTH registers, synchronous write, asynchronous head read.
module ifetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    // Entry storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch with prefetch queue, redirect flush and memory-port arbitration.
// Optional IFETCH_BYPASS_EN presents a return directly to decode when the queue is empty.
module ifetch
    import cpu_pkg::*;
#(
    parameter int unsigned       AWIDTH   = CPU_AWIDTH,
    parameter int unsigned       IWIDTH   = CPU_IWIDTH,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(CPU_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [AWIDTH-1:0] mem_raddr_o,
    output logic              mem_rd_o,
    input  logic [IWIDTH-1:0] mem_rdata_i,
    input  logic              mem_busy_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic [IWIDTH-1:0] ir_o,
    output logic [AWIDTH-1:0] ir_pc_o,
    output logic              ir_valid_o,
    input  logic              ir_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = CW + 1;
    localparam int unsigned EW = AWIDTH + IWIDTH;

    logic [AWIDTH-1:0] fetch_pc;
    logic [AWIDTH-1:0] rec_pc;
    logic [AWIDTH-1:0] issue_addr;
    logic              inflight;
    logic              squash;
    logic              issue;
    logic              pop;
    logic              q_pop;
    logic              push;
    logic              bypass_valid;
    logic [CW-1:0]     count;
    logic [OW-1:0]     occ;
    logic [EW-1:0]     head;

    // A redirect kills the return arriving this cycle.
    assign squash = inflight & redirect_i;

`ifdef IFETCH_BYPASS_EN
    assign bypass_valid = inflight & ~squash & (count == '0);
`else
    assign bypass_valid = 1'b0;
`endif

    assign ir_valid_o = (count != '0) | bypass_valid;
    assign ir_pc_o    = bypass_valid ? rec_pc      : head[EW-1:IWIDTH];
    assign ir_o       = bypass_valid ? mem_rdata_i : head[IWIDTH-1:0];

    assign pop   = ir_valid_o & ir_ready_i;
    assign q_pop = pop & (count != '0) & ~redirect_i;
    assign push  = inflight & ~squash & ~(bypass_valid & ir_ready_i);

    // Occupancy after this cycle's push/pop; issuing only below DEPTH guarantees space for the return.
    assign occ   = OW'(count) + OW'(inflight) - OW'(pop);
    assign issue = reset_n & ~mem_busy_i & (redirect_i | (occ < OW'(DEPTH)));

    assign issue_addr  = redirect_i ? redirect_pc_i : fetch_pc;
    assign mem_rd_o    = issue;
    assign mem_raddr_o = reset_n ? issue_addr : RESET_PC;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            rec_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                rec_pc   <= issue_addr;
                fetch_pc <= issue_addr + AWIDTH'(1);
            end else if (redirect_i) begin
                fetch_pc <= redirect_pc_i;
            end
        end
    end

    ifetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (redirect_i),
        .push    (push),
        .pop     (q_pop),
        .wdata   ({rec_pc, mem_rdata_i}),
        .rdata   (head),
        .count   (count)
    );

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch: fill, streaming, redirect, busy stall, wrap, reset mid-read.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] mem_raddr_o;
    logic        mem_rd_o;
    logic [15:0] mem_rdata_i = '0;
    logic        mem_busy_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [15:0] redirect_pc_i = '0;
    logic [15:0] ir_o;
    logic [15:0] ir_pc_o;
    logic        ir_valid_o;
    logic        ir_ready_i = 1'b0;

    int total = 0;
    int bad   = 0;

`ifdef IFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    always #5 clk = ~clk;

    ifetch dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_raddr_o   (mem_raddr_o),
        .mem_rd_o      (mem_rd_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_busy_i    (mem_busy_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ir_o          (ir_o),
        .ir_pc_o       (ir_pc_o),
        .ir_valid_o    (ir_valid_o),
        .ir_ready_i    (ir_ready_i)
    );

    function automatic logic [15:0] dat(input logic [15:0] a);
        return (a ^ 16'hC3A5) + 16'h0101;
    endfunction

    // Memory model: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_o) mem_rdata_i <= dat(mem_raddr_o);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        redirect_i = 1'b0;
        mem_busy_i = 1'b0;
        ir_ready_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h1234;
        step();
        step();
        #1;
        total++; if (mem_rd_o !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b want 0", mem_rd_o); end
        total++; if (ir_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ir_valid_o); end
        total++; if (mem_raddr_o !== 16'h0000) begin bad++; $display("FAIL reset_raddr: got %h want 0000", mem_raddr_o); end
        redirect_i = 1'b0;
    endtask

    task automatic test_fill();
        apply_reset();
        reset_n = 1'b1;
        #1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin step(); #1; end
            total++;
            if (mem_rd_o !== 1'(k < 4)) begin bad++; $display("FAIL fill_rd[%0d]: got %b want %b", k, mem_rd_o, k < 4); end
            if (k < 4) begin
                total++;
                if (mem_raddr_o !== 16'(k)) begin bad++; $display("FAIL fill_addr[%0d]: got %h want %h", k, mem_raddr_o, 16'(k)); end
            end
        end
        total++; if (ir_valid_o !== 1'b1) begin bad++; $display("FAIL fill_valid: got %b want 1", ir_valid_o); end
        total++; if (ir_pc_o !== 16'h0000) begin bad++; $display("FAIL fill_pc: got %h want 0000", ir_pc_o); end
        total++; if (ir_o !== dat(16'h0000)) begin bad++; $display("FAIL fill_ir: got %h want %h", ir_o, dat(16'h0000)); end
    endtask

    task automatic test_stream();
        int          first;
        logic [15:0] exp;
        first = -1;
        exp   = '0;
        apply_reset();
        ir_ready_i = 1'b1;
        reset_n    = 1'b1;
        #1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin step(); #1; end
            if (ir_valid_o) begin
                if (first < 0) first = k;
                total++;
                if (ir_pc_o !== exp || ir_o !== dat(exp)) begin
                    bad++; $display("FAIL stream_pc[%0d]: got pc=%h ir=%h want pc=%h ir=%h", k, ir_pc_o, ir_o, exp, dat(exp));
                end
                exp = exp + 16'd1;
            end else if (first >= 0) begin
                total++; bad++; $display("FAIL stream_gap[%0d]: got valid=0 want 1", k);
            end
        end
        total++; if (first != LAT) begin bad++; $display("FAIL stream_latency: got %0d want %0d", first, LAT); end
        total++; if (exp !== 16'(12 - LAT)) begin bad++; $display("FAIL stream_count: got %0d want %0d", exp, 12 - LAT); end
    endtask

    task automatic test_redirect();
        bit found;
        found = 1'b0;
        apply_reset();
        reset_n = 1'b1;
        #1;
        for (int k = 1; k <= 4; k++) begin step(); #1; end
        total++; if (ir_valid_o !== 1'b1 || ir_pc_o !== 16'h0000) begin bad++; $display("FAIL redir_pre: got valid=%b pc=%h want 1/0000", ir_valid_o, ir_pc_o); end
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h0040;
        #1;
        total++; if (mem_rd_o !== 1'b1 || mem_raddr_o !== 16'h0040) begin bad++; $display("FAIL redir_issue: got rd=%b addr=%h want 1/0040", mem_rd_o, mem_raddr_o); end
        step();
        redirect_i = 1'b0;
        ir_ready_i = 1'b1;
        #1;
        total++; if (mem_rd_o !== 1'b1 || mem_raddr_o !== 16'h0041) begin bad++; $display("FAIL redir_next: got rd=%b addr=%h want 1/0041", mem_rd_o, mem_raddr_o); end
        for (int k = 0; k < 4 && !found; k++) begin
            if (k > 0) begin step(); #1; end
            if (ir_valid_o) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL redir_timeout: got no valid want valid"); end
        total++; if (ir_pc_o !== 16'h0040 || ir_o !== dat(16'h0040)) begin bad++; $display("FAIL redir_head: got pc=%h ir=%h want 0040/%h", ir_pc_o, ir_o, dat(16'h0040)); end
        for (int k = 1; k <= 2; k++) begin
            step(); #1;
            total++;
            if (ir_valid_o !== 1'b1 || ir_pc_o !== 16'h0040 + 16'(k)) begin
                bad++; $display("FAIL redir_seq[%0d]: got valid=%b pc=%h want 1/%h", k, ir_valid_o, ir_pc_o, 16'h0040 + 16'(k));
            end
        end
        ir_ready_i = 1'b0;
    endtask

    task automatic test_busy();
        logic [15:0] exp;
        exp = '0;
        apply_reset();
        ir_ready_i = 1'b1;
        reset_n    = 1'b1;
        #1;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) begin step(); mem_busy_i = (k >= 5 && k <= 7); #1; end
            if (k < 5) begin
                total++; if (mem_rd_o !== 1'b1 || mem_raddr_o !== 16'(k)) begin bad++; $display("FAIL busy_pre[%0d]: got rd=%b addr=%h want 1/%h", k, mem_rd_o, mem_raddr_o, 16'(k)); end
            end else if (k <= 7) begin
                total++; if (mem_rd_o !== 1'b0) begin bad++; $display("FAIL busy_hold[%0d]: got rd=%b want 0", k, mem_rd_o); end
            end else if (k == 8) begin
                total++; if (mem_rd_o !== 1'b1 || mem_raddr_o !== 16'h0005) begin bad++; $display("FAIL busy_resume: got rd=%b addr=%h want 1/0005", mem_rd_o, mem_raddr_o); end
            end
            if (ir_valid_o) begin
                total++;
                if (ir_pc_o !== exp || ir_o !== dat(exp)) begin bad++; $display("FAIL busy_seq[%0d]: got pc=%h want %h", k, ir_pc_o, exp); end
                exp = exp + 16'd1;
            end
        end
        mem_busy_i = 1'b0;
        total++; if (exp < 16'd12) begin bad++; $display("FAIL busy_count: got %0d want >=12", exp); end
    endtask

    task automatic test_wrap();
        bit found;
        found = 1'b0;
        apply_reset();
        ir_ready_i = 1'b1;
        reset_n    = 1'b1;
        #1;
        step(); #1;
        step(); #1;
        redirect_i    = 1'b1;
        redirect_pc_i = 16'hFFFF;
        #1;
        total++; if (mem_rd_o !== 1'b1 || mem_raddr_o !== 16'hFFFF) begin bad++; $display("FAIL wrap_issue0: got rd=%b addr=%h want 1/ffff", mem_rd_o, mem_raddr_o); end
        step();
        redirect_i = 1'b0;
        #1;
        total++; if (mem_rd_o !== 1'b1 || mem_raddr_o !== 16'h0000) begin bad++; $display("FAIL wrap_issue1: got rd=%b addr=%h want 1/0000", mem_rd_o, mem_raddr_o); end
        for (int k = 0; k < 4 && !found; k++) begin
            if (k > 0) begin step(); #1; end
            if (ir_valid_o) found = 1'b1;
        end
        total++; if (!found || ir_pc_o !== 16'hFFFF) begin bad++; $display("FAIL wrap_head: got valid=%b pc=%h want 1/ffff", ir_valid_o, ir_pc_o); end
        step(); #1;
        total++; if (ir_valid_o !== 1'b1 || ir_pc_o !== 16'h0000 || ir_o !== dat(16'h0000)) begin bad++; $display("FAIL wrap_next: got valid=%b pc=%h want 1/0000", ir_valid_o, ir_pc_o); end
        ir_ready_i = 1'b0;
    endtask

    task automatic test_reset_inflight();
        bit found;
        found = 1'b0;
        apply_reset();
        reset_n = 1'b1;
        #1;
        step(); #1;
        step(); #1;
        total++; if (mem_rd_o !== 1'b1 || mem_raddr_o !== 16'h0002) begin bad++; $display("FAIL rst_pre: got rd=%b addr=%h want 1/0002", mem_rd_o, mem_raddr_o); end
        reset_n = 1'b0;
        #1;
        total++; if (mem_rd_o !== 1'b0 || ir_valid_o !== 1'b0 || mem_raddr_o !== 16'h0000) begin
            bad++; $display("FAIL rst_force: got rd=%b valid=%b addr=%h want 0/0/0000", mem_rd_o, ir_valid_o, mem_raddr_o);
        end
        step();
        step();
        ir_ready_i = 1'b1;
        reset_n    = 1'b1;
        #1;
        total++; if (mem_rd_o !== 1'b1 || mem_raddr_o !== 16'h0000) begin bad++; $display("FAIL rst_restart: got rd=%b addr=%h want 1/0000", mem_rd_o, mem_raddr_o); end
        for (int k = 0; k < 4 && !found; k++) begin
            if (k > 0) begin step(); #1; end
            if (ir_valid_o) found = 1'b1;
        end
        total++; if (!found || ir_pc_o !== 16'h0000 || ir_o !== dat(16'h0000)) begin bad++; $display("FAIL rst_head: got valid=%b pc=%h ir=%h want 1/0000/%h", ir_valid_o, ir_pc_o, ir_o, dat(16'h0000)); end
        for (int k = 1; k <= 2; k++) begin
            step(); #1;
            total++;
            if (ir_valid_o !== 1'b1 || ir_pc_o !== 16'(k)) begin bad++; $display("FAIL rst_seq[%0d]: got valid=%b pc=%h want 1/%h", k, ir_valid_o, ir_pc_o, 16'(k)); end
        end
        ir_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_redirect();
        test_busy();
        test_wrap();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
